// File: rtl/blit_queue.sv
// blit_queue: CPU-staged blit descriptor FIFO with a sequencer that replays
// each queued descriptor into the fill blitter's register port, kicks it and
// waits for the blitter to finish before retiring the entry.
module blit_queue #(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  cpu_wr,
  input  logic [3:0]  cpu_addr,
  input  logic [15:0] cpu_din,
  output logic [15:0] cpu_dout,
  output logic [1:0]  bl_wr,
  output logic [15:0] bl_addr,
  output logic [15:0] bl_din,
  input  logic        bl_active,
  output logic        cmd_done
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int NF = 5;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  typedef logic [NF-1:0][15:0] desc_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_KICK,
    S_WAIT_ACT,
    S_WAIT_DONE
  } state_e;

  desc_t           stg_q;
  desc_t           fifo_mem [DEPTH];
  desc_t           head;
  logic [AW-1:0]   wr_ptr_q;
  logic [AW-1:0]   rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic            ovf_q;
  logic [15:0]     done_cnt_q;
  logic [15:0]     cpu_dout_q;
  logic [15:0]     rd_data;
  logic [15:0]     status;
  logic [7:0]      count_ext;

  state_e          state_q, state_d;
  logic [2:0]      k_q, k_d;
  logic [1:0]      bl_wr_q, bl_wr_d;
  logic [15:0]     bl_addr_q, bl_addr_d;
  logic [15:0]     bl_din_q, bl_din_d;
  logic            cmd_done_q, cmd_done_d;

  logic            stg_sel;
  logic [2:0]      stg_idx;
  logic            push_req;
  logic            push_ok;
  logic            pop;
  logic            fifo_empty;
  logic            fifo_full;
  logic            busy;
  logic            ovf_clear;

  assign stg_sel    = (cpu_addr < 4'd5);
  assign stg_idx    = cpu_addr[2:0];
  assign push_req   = cpu_wr[0] && (cpu_addr == 4'd7);
  assign ovf_clear  = cpu_wr[0] && (cpu_addr == 4'd5) && cpu_din[3];
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == FULL_COUNT);
  // A full FIFO rejects the push even when the head retires in the same cycle.
  assign push_ok    = push_req && !fifo_full;
  // The head only retires once the blitter has actually finished it.
  assign pop        = (state_q == S_WAIT_DONE) && !bl_active;
  assign busy       = (state_q != S_IDLE);
  assign head       = fifo_mem[rd_ptr_q];
  assign count_ext  = 8'(count_q);
  assign status     = {count_ext, 4'b0000, ovf_q, fifo_full, fifo_empty, busy};

  assign cpu_dout   = cpu_dout_q;
  assign bl_wr      = bl_wr_q;
  assign bl_addr    = bl_addr_q;
  assign bl_din     = bl_din_q;
  assign cmd_done   = cmd_done_q;

  // Staging registers take byte-merged CPU writes; a push does not clear them.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stg_q <= '0;
    end else if (stg_sel) begin
      if (cpu_wr[0]) stg_q[stg_idx][7:0]  <= cpu_din[7:0];
      if (cpu_wr[1]) stg_q[stg_idx][15:8] <= cpu_din[15:8];
    end
  end

  // Descriptor storage; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr_q] <= stg_q;
  end

  // FIFO pointers and occupancy; the in-flight command still counts.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_ok, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Sticky overflow flag and wrapping completed-command counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf_q      <= 1'b0;
      done_cnt_q <= '0;
    end else begin
      if (push_req && fifo_full) ovf_q <= 1'b1;
      else if (ovf_clear)        ovf_q <= 1'b0;
      if (pop) done_cnt_q <= done_cnt_q + 16'd1;
    end
  end

  // CPU read mux; unmapped addresses read as zero.
  always_comb begin
    rd_data = '0;
    case (cpu_addr)
      4'd0, 4'd1, 4'd2, 4'd3, 4'd4: rd_data = stg_q[stg_idx];
      4'd5:                         rd_data = status;
      4'd6:                         rd_data = done_cnt_q;
      default:                      rd_data = '0;
    endcase
  end

  // Read data is registered so it reflects state before the current edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cpu_dout_q <= '0;
    else          cpu_dout_q <= rd_data;
  end

  // Sequencer state, field index and registered blitter-side outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      k_q        <= '0;
      bl_wr_q    <= '0;
      bl_addr_q  <= '0;
      bl_din_q   <= '0;
      cmd_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      bl_wr_q    <= bl_wr_d;
      bl_addr_q  <= bl_addr_d;
      bl_din_q   <= bl_din_d;
      cmd_done_q <= cmd_done_d;
    end
  end

  // Next-state: load five fields, kick, then track the blitter busy flag.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          state_d = S_LOAD;
          k_d     = '0;
        end
      end
      S_LOAD: begin
        if (k_q == 3'd4) state_d = S_KICK;
        else             k_d     = k_q + 3'd1;
      end
      S_KICK:      state_d = S_WAIT_ACT;
      S_WAIT_ACT:  if (bl_active)  state_d = S_WAIT_DONE;
      S_WAIT_DONE: if (!bl_active) state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // Output decode: only LOAD and KICK write; otherwise address/data hold.
  always_comb begin
    bl_wr_d    = 2'b00;
    bl_addr_d  = bl_addr_q;
    bl_din_d   = bl_din_q;
    cmd_done_d = pop;
    case (state_q)
      S_LOAD: begin
        bl_wr_d   = 2'b11;
        bl_addr_d = {13'd0, k_q};
        bl_din_d  = head[k_q];
      end
      S_KICK: begin
        bl_wr_d   = 2'b01;
        bl_addr_d = 16'd7;
        bl_din_d  = 16'd0;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_blit_queue.sv
// tb_blit_queue: drives blit_queue from a CPU-side task layer, models the
// blitter as a timed busy flag and compares every blitter write, status word
// and counter against a queue-based reference of accepted descriptors.
module tb_blit_queue;

  localparam int DEPTH = 8;

  typedef logic [4:0][15:0] desc_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  cpu_wr;
  logic [3:0]  cpu_addr;
  logic [15:0] cpu_din;
  logic [15:0] cpu_dout;
  logic [1:0]  bl_wr;
  logic [15:0] bl_addr;
  logic [15:0] bl_din;
  logic        bl_active = 1'b0;
  logic        cmd_done;

  int checks = 0;
  int failures = 0;

  desc_t       expDesc[$];
  desc_t       modelStg;
  logic        modelOvf;
  logic [33:0] wrLog[$];
  int          donePulses = 0;
  int          activeWriteViolations = 0;
  int          logBase = 0;
  int          doneBase = 0;

  bit holdActive = 1'b0;
  int busyLen = 1;
  int busyLeft = 0;
  bit kickPending = 1'b0;

  always #5 clk = ~clk;

  blit_queue #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cpu_wr    (cpu_wr),
    .cpu_addr  (cpu_addr),
    .cpu_din   (cpu_din),
    .cpu_dout  (cpu_dout),
    .bl_wr     (bl_wr),
    .bl_addr   (bl_addr),
    .bl_din    (bl_din),
    .bl_active (bl_active),
    .cmd_done  (cmd_done)
  );

  // Blitter model: a kick seen on the port starts a busy period of busyLen
  // cycles, or an indefinite one while holdActive is set.
  always begin
    @(posedge clk);
    #1;
    if (!reset_n) begin
      bl_active   = 1'b0;
      busyLeft    = 0;
      kickPending = 1'b0;
    end else begin
      if (bl_active && !holdActive) begin
        if (busyLeft > 0) busyLeft--;
        if (busyLeft == 0) bl_active = 1'b0;
      end
      if (kickPending) begin
        kickPending = 1'b0;
        bl_active   = 1'b1;
        busyLeft    = busyLen;
      end
      if (bl_wr == 2'b01 && bl_addr == 16'd7) kickPending = 1'b1;
    end
  end

  // Port monitor: logs every blitter write and every done pulse mid-cycle.
  always @(negedge clk) begin
    if (reset_n) begin
      if (bl_wr != 2'b00) begin
        wrLog.push_back({bl_addr, bl_wr, bl_din});
        if (bl_active) activeWriteViolations++;
      end
      if (cmd_done) donePulses++;
    end
  end

  // Time limit so the run always ends.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic desc_t randDesc();
    desc_t d;
    for (int k = 0; k < 5; k++) d[k] = 16'($urandom);
    return d;
  endfunction

  // Expected i-th blitter write of the accepted descriptor stream.
  function automatic logic [33:0] expectedWrite(input int i);
    int j;
    int f;
    j = i / 6;
    f = i % 6;
    if (f < 5) return {16'(f), 2'b11, expDesc[j][f]};
    return {16'd7, 2'b01, 16'd0};
  endfunction

  function automatic logic [15:0] expStatus();
    int cnt;
    cnt = expDesc.size() - (donePulses - doneBase);
    return {8'(cnt), 4'b0000, modelOvf, (cnt == DEPTH), (cnt == 0), (cnt != 0)};
  endfunction

  // All CPU tasks are entered and left on a falling edge.
  task automatic cpuWrite(input logic [3:0] a, input logic [1:0] we, input logic [15:0] d);
    cpu_addr = a;
    cpu_wr   = we;
    cpu_din  = d;
    @(negedge clk);
    cpu_wr   = 2'b00;
  endtask

  task automatic cpuRead(input logic [3:0] a, output logic [15:0] d);
    cpu_addr = a;
    cpu_wr   = 2'b00;
    @(negedge clk);
    d = cpu_dout;
  endtask

  // CPU write that also updates the reference model.
  task automatic regWrite(input logic [3:0] a, input logic [1:0] we, input logic [15:0] d);
    int inQueue;
    if (a < 4'd5) begin
      if (we[0]) modelStg[a[2:0]][7:0]  = d[7:0];
      if (we[1]) modelStg[a[2:0]][15:8] = d[15:8];
    end else if (a == 4'd5 && we[0] && d[3]) begin
      modelOvf = 1'b0;
    end else if (a == 4'd7 && we[0]) begin
      inQueue = expDesc.size() - (donePulses - doneBase);
      if (inQueue >= DEPTH) modelOvf = 1'b1;
      else                  expDesc.push_back(modelStg);
    end
    cpuWrite(a, we, d);
  endtask

  task automatic stagePush(input desc_t d);
    for (int k = 0; k < 5; k++) regWrite(4'(k), 2'b11, d[k]);
    regWrite(4'd7, {1'($urandom), 1'b1}, 16'($urandom));
  endtask

  task automatic waitDone(input int target, input int maxCycles);
    int n;
    n = 0;
    while ((donePulses - doneBase) < target && n < maxCycles) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    checks++;
    if ((donePulses - doneBase) !== target) begin
      failures++;
      $display("[TB] FAIL done_pulses: got %0d expected %0d", donePulses - doneBase, target);
    end
  endtask

  task automatic doReset();
    reset_n    = 1'b0;
    cpu_wr     = 2'b00;
    cpu_addr   = 4'd0;
    cpu_din    = 16'd0;
    holdActive = 1'b0;
    busyLen    = 1;
    repeat (3) @(negedge clk);
    reset_n  = 1'b1;
    expDesc.delete();
    modelStg = '0;
    modelOvf = 1'b0;
    logBase  = wrLog.size();
    doneBase = donePulses;
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [15:0] r;
    $display("[TB] test_reset");
    doReset();
    checks++;
    if ({cpu_dout, bl_wr, bl_addr, bl_din, cmd_done} !== 51'd0) begin
      failures++;
      $display("[TB] FAIL reset_outputs: got dout=%h wr=%b addr=%h din=%h done=%b expected all zero",
               cpu_dout, bl_wr, bl_addr, bl_din, cmd_done);
    end
    cpuRead(4'd5, r);
    checks++;
    if (r !== 16'h0002) begin
      failures++;
      $display("[TB] FAIL reset_status: got %h expected 0002", r);
    end
    for (int k = 0; k < 5; k++) begin
      cpuRead(4'(k), r);
      checks++;
      if (r !== 16'h0000) begin
        failures++;
        $display("[TB] FAIL reset_staging%0d: got %h expected 0000", k, r);
      end
    end
    cpuRead(4'd6, r);
    checks++;
    if (r !== 16'h0000) begin
      failures++;
      $display("[TB] FAIL reset_donecnt: got %h expected 0000", r);
    end
  endtask

  task automatic test_basic();
    logic [15:0] r;
    $display("[TB] test_basic");
    doReset();
    busyLen = 8;
    regWrite(4'd0, 2'b11, 16'hAAAA);
    regWrite(4'd1, 2'b11, 16'd3);
    regWrite(4'd2, 2'b11, 16'd1);
    regWrite(4'd3, 2'b11, 16'd1);
    regWrite(4'd4, 2'b11, 16'h0100);
    regWrite(4'd7, 2'b01, 16'd0);
    checks++;
    if (bl_wr !== 2'b00) begin
      failures++;
      $display("[TB] FAIL latency_e0: got wr=%b expected 00", bl_wr);
    end
    @(negedge clk);
    checks++;
    if (bl_wr !== 2'b00) begin
      failures++;
      $display("[TB] FAIL latency_e1: got wr=%b expected 00", bl_wr);
    end
    @(negedge clk);
    checks++;
    if ({bl_wr, bl_addr, bl_din} !== {2'b11, 16'd0, 16'hAAAA}) begin
      failures++;
      $display("[TB] FAIL latency_e2: got wr=%b addr=%h din=%h expected 11/0000/aaaa", bl_wr, bl_addr, bl_din);
    end
    waitDone(1, 200);
    checks++;
    if (wrLog.size() - logBase !== 6) begin
      failures++;
      $display("[TB] FAIL basic_nwrites: got %0d expected 6", wrLog.size() - logBase);
    end
    for (int i = 0; i < 6 && logBase + i < wrLog.size(); i++) begin
      checks++;
      if (wrLog[logBase + i] !== expectedWrite(i)) begin
        failures++;
        $display("[TB] FAIL basic_write%0d: got %h expected %h", i, wrLog[logBase + i], expectedWrite(i));
      end
    end
    cpuRead(4'd5, r);
    checks++;
    if (r !== expStatus()) begin
      failures++;
      $display("[TB] FAIL basic_status: got %h expected %h", r, expStatus());
    end
    cpuRead(4'd6, r);
    checks++;
    if (r !== 16'd1) begin
      failures++;
      $display("[TB] FAIL basic_donecnt: got %h expected 0001", r);
    end
    cpuRead(4'd4, r);
    checks++;
    if (r !== 16'h0100) begin
      failures++;
      $display("[TB] FAIL basic_staging_kept: got %h expected 0100", r);
    end
  endtask

  task automatic test_byte_enables();
    logic [15:0] r;
    logic [3:0]  a;
    $display("[TB] test_byte_enables");
    doReset();
    regWrite(4'd0, 2'b11, 16'h3456);
    regWrite(4'd0, 2'b10, 16'h12FF);
    cpuRead(4'd0, r);
    checks++;
    if (r !== 16'h1256) begin
      failures++;
      $display("[TB] FAIL byte_merge: got %h expected 1256", r);
    end
    for (int n = 0; n < 16; n++) begin
      a = 4'($urandom_range(0, 11));
      if (a == 4'd5) a = 4'd6;
      if (a == 4'd7) a = 4'd15;
      regWrite(a, 2'($urandom), 16'($urandom));
    end
    for (int k = 0; k < 5; k++) begin
      cpuRead(4'(k), r);
      checks++;
      if (r !== modelStg[k]) begin
        failures++;
        $display("[TB] FAIL rand_staging%0d: got %h expected %h", k, r, modelStg[k]);
      end
    end
    cpuRead(4'd6, r);
    checks++;
    if (r !== 16'd0) begin
      failures++;
      $display("[TB] FAIL donecnt_readonly: got %h expected 0000", r);
    end
    a = 4'($urandom_range(8, 15));
    cpuRead(a, r);
    checks++;
    if (r !== 16'd0) begin
      failures++;
      $display("[TB] FAIL unmapped_read%0d: got %h expected 0000", a, r);
    end
  endtask

  task automatic test_drain();
    logic [15:0] r;
    int n;
    $display("[TB] test_drain");
    doReset();
    busyLen = $urandom_range(1, 6);
    for (int c = 0; c < 3; c++) stagePush(randDesc());
    n = 0;
    while (cmd_done !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (cmd_done !== 1'b1) begin
      failures++;
      $display("[TB] FAIL first_done_seen: got %b expected 1", cmd_done);
    end
    @(negedge clk);
    checks++;
    if (bl_wr !== 2'b00) begin
      failures++;
      $display("[TB] FAIL b2b_gap: got wr=%b expected 00", bl_wr);
    end
    @(negedge clk);
    checks++;
    if ({bl_wr, bl_addr} !== {2'b11, 16'd0}) begin
      failures++;
      $display("[TB] FAIL b2b_load: got wr=%b addr=%h expected 11/0000", bl_wr, bl_addr);
    end
    waitDone(3, 300);
    checks++;
    if (wrLog.size() - logBase !== 18) begin
      failures++;
      $display("[TB] FAIL drain_nwrites: got %0d expected 18", wrLog.size() - logBase);
    end
    for (int i = 0; i < 18 && logBase + i < wrLog.size(); i++) begin
      checks++;
      if (wrLog[logBase + i] !== expectedWrite(i)) begin
        failures++;
        $display("[TB] FAIL drain_write%0d: got %h expected %h", i, wrLog[logBase + i], expectedWrite(i));
      end
    end
    cpuRead(4'd6, r);
    checks++;
    if (r !== 16'd3) begin
      failures++;
      $display("[TB] FAIL drain_donecnt: got %h expected 0003", r);
    end
  endtask

  task automatic test_fill_capacity();
    logic [15:0] r;
    logic [15:0] e;
    $display("[TB] test_fill_capacity");
    doReset();
    holdActive = 1'b1;
    busyLen    = 1;
    for (int c = 0; c < DEPTH + 1; c++) stagePush(randDesc());
    repeat (20) @(negedge clk);
    checks++;
    if (wrLog.size() - logBase !== 6) begin
      failures++;
      $display("[TB] FAIL held_nwrites: got %0d expected 6", wrLog.size() - logBase);
    end
    cpuRead(4'd5, r);
    e = expStatus();
    checks++;
    if (r !== e) begin
      failures++;
      $display("[TB] FAIL full_status: got %h expected %h", r, e);
    end
    regWrite(4'd5, 2'b01, 16'h0000);
    cpuRead(4'd5, r);
    e = expStatus();
    checks++;
    if (r !== e) begin
      failures++;
      $display("[TB] FAIL ovf_noclear: got %h expected %h", r, e);
    end
    regWrite(4'd5, 2'b01, 16'h0008);
    cpuRead(4'd5, r);
    e = expStatus();
    checks++;
    if (r !== e) begin
      failures++;
      $display("[TB] FAIL ovf_clear: got %h expected %h", r, e);
    end
    holdActive = 1'b0;
    waitDone(DEPTH, DEPTH * 40);
    checks++;
    if (wrLog.size() - logBase !== 6 * DEPTH) begin
      failures++;
      $display("[TB] FAIL fill_nwrites: got %0d expected %0d", wrLog.size() - logBase, 6 * DEPTH);
    end
    for (int i = 0; i < 6 * DEPTH && logBase + i < wrLog.size(); i++) begin
      checks++;
      if (wrLog[logBase + i] !== expectedWrite(i)) begin
        failures++;
        $display("[TB] FAIL fill_write%0d: got %h expected %h", i, wrLog[logBase + i], expectedWrite(i));
      end
    end
    cpuRead(4'd5, r);
    e = expStatus();
    checks++;
    if (r !== e) begin
      failures++;
      $display("[TB] FAIL fill_end_status: got %h expected %h", r, e);
    end
  endtask

  task automatic test_push_pop();
    logic [15:0] r;
    desc_t d;
    int n;
    int cnt;
    $display("[TB] test_push_pop");
    doReset();
    holdActive = 1'b1;
    busyLen    = 1;
    stagePush(randDesc());
    stagePush(randDesc());
    d = randDesc();
    for (int k = 0; k < 5; k++) regWrite(4'(k), 2'b11, d[k]);
    repeat (10) @(negedge clk);
    cpuRead(4'd5, r);
    checks++;
    if (r[15:8] !== 8'd2) begin
      failures++;
      $display("[TB] FAIL pp_count_before: got %0d expected 2", r[15:8]);
    end
    holdActive = 1'b0;
    n = 0;
    while (bl_active && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bl_active !== 1'b0) begin
      failures++;
      $display("[TB] FAIL pp_active_fall: got %b expected 0", bl_active);
    end
    regWrite(4'd7, 2'b01, 16'd0);
    cpuRead(4'd5, r);
    cnt = expDesc.size() - (donePulses - doneBase);
    checks++;
    if (r[15:8] !== 8'(cnt) || cnt != 2) begin
      failures++;
      $display("[TB] FAIL pp_count_after: got %0d expected 2 (model %0d)", r[15:8], cnt);
    end
    busyLen = 3;
    waitDone(3, 300);
    checks++;
    if (wrLog.size() - logBase !== 18) begin
      failures++;
      $display("[TB] FAIL pp_nwrites: got %0d expected 18", wrLog.size() - logBase);
    end
    for (int i = 0; i < 18 && logBase + i < wrLog.size(); i++) begin
      checks++;
      if (wrLog[logBase + i] !== expectedWrite(i)) begin
        failures++;
        $display("[TB] FAIL pp_write%0d: got %h expected %h", i, wrLog[logBase + i], expectedWrite(i));
      end
    end
    cpuRead(4'd6, r);
    checks++;
    if (r !== 16'd3) begin
      failures++;
      $display("[TB] FAIL pp_donecnt: got %h expected 0003", r);
    end
  endtask

  task automatic test_reset_mid_load();
    logic [15:0] r;
    int n;
    $display("[TB] test_reset_mid_load");
    doReset();
    busyLen = 4;
    stagePush(randDesc());
    n = 0;
    while (!(bl_wr == 2'b11 && bl_addr == 16'd2) && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if ({bl_wr, bl_addr} !== {2'b11, 16'd2}) begin
      failures++;
      $display("[TB] FAIL reach_k2: got wr=%b addr=%h expected 11/0002", bl_wr, bl_addr);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({bl_wr, bl_addr, bl_din} !== 34'd0) begin
      failures++;
      $display("[TB] FAIL async_reset: got wr=%b addr=%h din=%h expected zeros", bl_wr, bl_addr, bl_din);
    end
    @(negedge clk);
    reset_n  = 1'b1;
    expDesc.delete();
    modelStg = '0;
    modelOvf = 1'b0;
    logBase  = wrLog.size();
    doneBase = donePulses;
    repeat (30) @(negedge clk);
    checks++;
    if (wrLog.size() - logBase !== 0) begin
      failures++;
      $display("[TB] FAIL post_reset_writes: got %0d expected 0", wrLog.size() - logBase);
    end
    cpuRead(4'd5, r);
    checks++;
    if (r !== 16'h0002) begin
      failures++;
      $display("[TB] FAIL post_reset_status: got %h expected 0002", r);
    end
    checks++;
    if (activeWriteViolations !== 0) begin
      failures++;
      $display("[TB] FAIL write_while_active: got %0d expected 0", activeWriteViolations);
    end
  endtask

  initial begin
    reset_n  = 1'b0;
    cpu_wr   = 2'b00;
    cpu_addr = 4'd0;
    cpu_din  = 16'd0;
    modelStg = '0;
    modelOvf = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_byte_enables();
    test_drain();
    test_fill_capacity();
    test_push_pop();
    test_reset_mid_load();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
